// File: rtl/imem_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_loader_pkg
//   Shared types and constants for the instruction-memory loader.
//   - ldr_state_e : loader FSM encoding (3 bits, LDR_IDLE .. LDR_CHK)
//   - LDR_LEN_W   : width of the image length field (words)
//   - LDR_WORD_W  : instruction word width (only 32 is supported)
//   - ldr_chk_fold: running checksum update (XOR of payload bytes)
// ---------------------------------------------------------------------------
package imem_loader_pkg;

  typedef enum logic [2:0] {
    LDR_IDLE   = 3'd0,
    LDR_LEN_HI = 3'd1,
    LDR_LEN_LO = 3'd2,
    LDR_DATA   = 3'd3,
    LDR_DONE   = 3'd4,
    LDR_CHK    = 3'd5
  } ldr_state_e;

  localparam int LDR_LEN_W  = 16;
  localparam int LDR_WORD_W = 32;

  // Fold one payload byte into the running XOR checksum.
  function automatic logic [7:0] ldr_chk_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// ---------------------------------------------------------------------------
// imem_loader_byte_packer
//   Shifts in 8-bit bytes and presents a big-endian 32-bit word together with
//   a one-cycle word_valid_o on the handshake of every 4th byte.
//   Ports:
//     clk, rst_n     clock, synchronous active-low reset
//     clr_i          drop any partially assembled word
//     byte_valid_i   a byte is accepted this cycle
//     byte_i         the byte
//     word_valid_o   this byte completes a word (combinational)
//     word_o         {byte0, byte1, byte2, byte3}; valid with word_valid_o
// ---------------------------------------------------------------------------
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_i,
  output logic                  word_valid_o,
  output logic [LDR_WORD_W-1:0] word_o
);

  logic [23:0] shift_q;
  logic [1:0]  cnt_q;

  // Byte shift register and 2-bit byte count; count wraps after the 4th byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_q <= 24'h000000;
      cnt_q   <= 2'd0;
    end else if (clr_i) begin
      shift_q <= 24'h000000;
      cnt_q   <= 2'd0;
    end else if (byte_valid_i) begin
      shift_q <= {shift_q[15:0], byte_i};
      cnt_q   <= cnt_q + 2'd1;
    end else begin
      shift_q <= shift_q;
      cnt_q   <= cnt_q;
    end
  end

  // The 4th byte is taken straight from the input so the word is ready in
  // the same cycle as its last handshake.
  assign word_valid_o = byte_valid_i && (cnt_q == 2'd3);
  assign word_o       = {shift_q, byte_i};

endmodule

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//   Loads a framed byte stream into the CPU instruction memory and holds the
//   CPU in reset until a good image has been written.
//   Frame: LEN_HI, LEN_LO (N words), then 4*N big-endian payload bytes and,
//   when IMEM_LOADER_CHECKSUM_EN is defined, one XOR checksum byte.
//   Ports:
//     clk, rst_n     clock, synchronous active-low reset
//     start          arm a load (ignored while busy)
//     in_valid/in_data/in_ready   byte stream handshake
//     imem_we/imem_waddr/imem_wdata   one-cycle imem write per word
//     cpu_hold       hold CPU in reset (1 until a clean load completes)
//     busy, done, err             load status (done/err sticky until start)
//     words_loaded   number of words actually written
//   Optional feature macro: IMEM_LOADER_CHECKSUM_EN
// ---------------------------------------------------------------------------
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int IMEM_AW   = 8,
  parameter int INSTR_LEN = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  output logic                 imem_we,
  output logic [IMEM_AW-1:0]   imem_waddr,
  output logic [INSTR_LEN-1:0] imem_wdata,
  output logic                 cpu_hold,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [IMEM_AW:0]     words_loaded
);

  localparam logic [LDR_LEN_W:0] DEPTH_C = 17'd1 << IMEM_AW;
  localparam logic [IMEM_AW:0]   WL_ONE  = {{IMEM_AW{1'b0}}, 1'b1};

  ldr_state_e             state_q, state_d;
  logic [7:0]             len_hi_q, len_hi_d;
  logic [LDR_LEN_W-1:0]   len_q, len_d;
  logic [LDR_LEN_W-1:0]   word_cnt_q, word_cnt_d;
  logic                   rdy_q, rdy_d;
  logic                   we_q, we_d;
  logic [IMEM_AW-1:0]     waddr_q, waddr_d;
  logic [INSTR_LEN-1:0]   wdata_q, wdata_d;
  logic                   hold_q, hold_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [IMEM_AW:0]       wl_q, wl_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]             chk_q, chk_d;
`endif

  logic                   hs_s;
  logic                   pk_clr_s;
  logic                   pk_valid_s;
  logic                   pk_word_valid_s;
  logic [LDR_WORD_W-1:0]  pk_word_s;
  logic [LDR_LEN_W-1:0]   n_s;

  assign hs_s = in_valid && rdy_q;
  assign n_s  = {len_hi_q, in_data};

  imem_loader_byte_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (pk_clr_s),
    .byte_valid_i (pk_valid_s),
    .byte_i       (in_data),
    .word_valid_o (pk_word_valid_s),
    .word_o       (pk_word_s)
  );

  // Next-state, counters, write strobe and status.
  always_comb begin
    state_d    = state_q;
    len_hi_d   = len_hi_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    hold_d     = hold_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    wl_d       = wl_q;
    pk_clr_s   = 1'b0;
    pk_valid_s = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk_d      = chk_q;
`endif

    case (state_q)
      LDR_IDLE, LDR_DONE: begin
        if (start) begin
          state_d    = LDR_LEN_HI;
          len_hi_d   = 8'h00;
          len_d      = '0;
          word_cnt_d = '0;
          done_d     = 1'b0;
          err_d      = 1'b0;
          wl_d       = '0;
          busy_d     = 1'b1;
          hold_d     = 1'b1;
          pk_clr_s   = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          chk_d      = 8'h00;
`endif
        end else begin
          state_d = state_q;
        end
      end

      LDR_LEN_HI: begin
        if (hs_s) begin
          len_hi_d = in_data;
          state_d  = LDR_LEN_LO;
        end else begin
          state_d  = state_q;
        end
      end

      LDR_LEN_LO: begin
        if (hs_s) begin
          len_d = n_s;
          // Oversized image: flag now, keep consuming, suppress writes past depth.
          if ({1'b0, n_s} > DEPTH_C) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          if (n_s == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = LDR_CHK;
`else
            state_d = LDR_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            hold_d  = err_d;
`endif
          end else begin
            state_d = LDR_DATA;
          end
        end else begin
          state_d = state_q;
        end
      end

      LDR_DATA: begin
        if (hs_s) begin
          pk_valid_s = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          chk_d = ldr_chk_fold(chk_q, in_data);
`endif
          if (pk_word_valid_s) begin
            if ({1'b0, word_cnt_q} < DEPTH_C) begin
              we_d    = 1'b1;
              waddr_d = word_cnt_q[IMEM_AW-1:0];
              wdata_d = pk_word_s;
              wl_d    = wl_q + WL_ONE;
            end else begin
              we_d    = 1'b0;
            end
            word_cnt_d = word_cnt_q + 16'd1;
            if (word_cnt_d == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_d = LDR_CHK;
`else
              state_d = LDR_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              hold_d  = err_d;
`endif
            end else begin
              state_d = state_q;
            end
          end else begin
            state_d = state_q;
          end
        end else begin
          state_d = state_q;
        end
      end

      LDR_CHK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (hs_s) begin
          if (in_data != chk_q) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          state_d = LDR_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          hold_d  = err_d;
        end else begin
          state_d = state_q;
        end
`else
        // Unreachable without the checksum; recover to a safe idle.
        state_d = LDR_IDLE;
        busy_d  = 1'b0;
        hold_d  = 1'b1;
`endif
      end

      default: begin
        state_d = LDR_IDLE;
        busy_d  = 1'b0;
        hold_d  = 1'b1;
      end
    endcase

    // Stream is accepted in every active state; no backpressure is needed.
    rdy_d = (state_d == LDR_LEN_HI) || (state_d == LDR_LEN_LO) ||
            (state_d == LDR_DATA)   || (state_d == LDR_CHK);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= LDR_IDLE;
      len_hi_q   <= 8'h00;
      len_q      <= '0;
      word_cnt_q <= '0;
      rdy_q      <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      hold_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wl_q       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q      <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      len_hi_q   <= len_hi_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      rdy_q      <= rdy_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      hold_q     <= hold_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      wl_q       <= wl_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end

  assign in_ready     = rdy_q;
  assign imem_we      = we_q;
  assign imem_waddr   = waddr_q;
  assign imem_wdata   = wdata_q;
  assign cpu_hold     = hold_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = wl_q;

endmodule
